// File: rtl/bus_arbiter_rr_pkg.sv
// Shared widths and FSM encoding for the round-robin bus arbiter.
package bus_arbiter_rr_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 7;
    localparam int BE_W = XLEN / 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_priority_enc.sv
// Round-robin priority encoder: lowest-numbered request above `last`,
// otherwise (wrap-around) lowest-numbered request overall.
module rr_priority_enc #(
    parameter int N_PORTS = 2,
    parameter int ID_W    = 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    logic [ID_W-1:0] hi_pick;
    logic            hi_any;
    logic [ID_W-1:0] lo_pick;

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        hi_pick = '0;
        hi_any  = 1'b0;
        lo_pick = '0;
        any     = 1'b0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (req[j] && (ID_W'(j) > last)) begin
                hi_pick = ID_W'(j);
                hi_any  = 1'b1;
            end
            if (req[j]) begin
                lo_pick = ID_W'(j);
                any     = 1'b1;
            end
        end
        pick = hi_any ? hi_pick : lo_pick;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-port round-robin arbiter serialising single-beat bus transactions onto
// one memory_controller port, with ack/read-data routed back to the owner.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int ID_W    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_PORTS-1:0]        i_bus_en,
    input  logic [N_PORTS-1:0]        i_wr_en,
    input  logic [N_PORTS*XLEN-1:0]   i_wr_data,
    input  logic [N_PORTS*XLEN-1:0]   i_addr,
    input  logic [N_PORTS*BE_W-1:0]   i_byte_en,
    input  logic [N_PORTS-1:0]        i_atomic,
    input  logic [N_PORTS*OP_W-1:0]   i_operation,
    output logic [N_PORTS-1:0]        o_ack,
    output logic [N_PORTS*XLEN-1:0]   o_rd_data,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rd_data,
    output logic [ID_W-1:0]           o_id,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [XLEN-1:0]           o_wr_data,
    output logic [XLEN-1:0]           o_addr,
    output logic [BE_W-1:0]           o_byte_en,
    output logic                      o_atomic,
    output logic [OP_W-1:0]           o_operation
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              grant;
    logic [N_PORTS-1:0] sel;

    rr_priority_enc #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_prio (
        .req  (i_bus_en),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    // State, owner and round-robin pointer; last starts at N_PORTS-1 so port 0 wins first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(N_PORTS - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant from IDLE, release on ack (advancing last) or on owner abort (last kept).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_GRANT;
                    owner_d = pick;
                end
            end
            ARB_GRANT: begin
                if (i_ack) begin
                    last_d  = owner_q;
                    state_d = ARB_IDLE;
                end else if (!i_bus_en[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Reset forces IDLE asynchronously, so every output below drops with i_rst.
    assign grant    = (state_q == ARB_GRANT);
    assign o_bus_en = grant;
    assign o_id     = grant ? owner_q : '0;

    // Per-port select and return path: only the owner sees ack and read data.
    for (genvar k = 0; k < N_PORTS; k++) begin : g_port
        assign sel[k]                       = grant && (owner_q == ID_W'(k));
        assign o_ack[k]                     = sel[k] & i_ack;
        assign o_rd_data[k*XLEN +: XLEN]    = sel[k] ? i_rd_data : '0;
    end

    // Request mux: forward the owner's fields, zero when nothing is granted.
    always_comb begin
        o_wr_en     = 1'b0;
        o_wr_data   = '0;
        o_addr      = '0;
        o_byte_en   = '0;
        o_atomic    = 1'b0;
        o_operation = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (sel[k]) begin
                o_wr_en     = i_wr_en[k];
                o_wr_data   = i_wr_data[k*XLEN +: XLEN];
                o_addr      = i_addr[k*XLEN +: XLEN];
                o_byte_en   = i_byte_en[k*BE_W +: BE_W];
                o_atomic    = i_atomic[k];
                o_operation = i_operation[k*OP_W +: OP_W];
            end
        end
    end

endmodule
